// File: rtl/fcn_layer_sequencer_if.sv
// fcn_layer_sequencer_if: command, input/weight buffer, array and result-stream
// signals of the layer sequencer; master is the sequencer, slave its surroundings.
interface fcn_layer_sequencer_if #(
    parameter int SIZE    = 100,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 11
);
    localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;

    logic                 start;
    logic [ADDR_W:0]      cfg_len;
    logic                 cfg_relu;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic                 in_rd_en;
    logic [ADDR_W-1:0]    in_addr;
    logic [31:0]          in_rd_data;
    logic                 wt_rd_en;
    logic [WADDR_W-1:0]   wt_addr;
    logic                 arr_clr_n;
    logic [31:0]          arr_input;
    logic [32*SIZE-1:0]   arr_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [IW-1:0]        res_idx;
    logic [31:0]          res_data;

    modport master (
        input  start, cfg_len, cfg_relu, in_rd_data, arr_out, res_ready,
        output busy, done, cfg_err, in_rd_en, in_addr, wt_rd_en, wt_addr,
               arr_clr_n, arr_input, res_valid, res_idx, res_data
    );

    modport slave (
        output start, cfg_len, cfg_relu, in_rd_data, arr_out, res_ready,
        input  busy, done, cfg_err, in_rd_en, in_addr, wt_rd_en, wt_addr,
               arr_clr_n, arr_input, res_valid, res_idx, res_data
    );
endinterface

// File: rtl/fcn_layer_sequencer.sv
// fcn_layer_sequencer: runs one fully-connected layer pass through the systolic MAC array
// (clear, skewed stream plus drain, then valid/ready readout of the column accumulators).
module fcn_layer_sequencer #(
    parameter int SIZE    = 100,
    parameter int IN_MAX  = 1024,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 11
) (
    input logic                   clk,
    input logic                   rst_n,
    fcn_layer_sequencer_if.master bus
);
    localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam int CW = WADDR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIME   = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_READOUT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic                  relu_q, relu_d;
    logic                  err_q, err_d;
    logic                  rv_q;
    logic [CW-1:0]         k_q, k_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         k1, n_ext, last_k;
    logic [SIZE-1:0][31:0] cols;
    logic [31:0]           col;
    logic                  last_idx;

    // k counts stream cycles 0..N+SIZE-2; one extra bit keeps k+1 from wrapping
    assign n_ext    = CW'(len_q);
    assign k1       = k_q + 1'b1;
    assign last_k   = n_ext + CW'(SIZE - 2);
    assign cols     = bus.arr_out;
    assign col      = cols[idx_q];
    assign last_idx = idx_q == IW'(SIZE - 1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        relu_d  = relu_q;
        err_d   = err_q;
        k_d     = k_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (32'(bus.cfg_len) > IN_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        len_d   = bus.cfg_len;
                        relu_d  = bus.cfg_relu;
                        err_d   = 1'b0;
                        k_d     = '0;
                        idx_d   = '0;
                        state_d = S_PRIME;
                    end
                end
            end
            S_PRIME:  state_d = len_q != '0 ? S_STREAM : S_READOUT;
            S_STREAM: begin
                k_d     = k1;
                state_d = k_q == last_k ? S_READOUT : S_STREAM;
            end
            S_READOUT: begin
                if (bus.res_ready) begin
                    idx_d   = last_idx ? '0 : idx_q + 1'b1;
                    state_d = last_idx ? S_DONE : S_READOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            relu_q  <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            k_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            err_q   <= err_d;
            rv_q    <= bus.in_rd_en;
            k_q     <= k_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy      = state_q == S_PRIME || state_q == S_STREAM || state_q == S_READOUT;
    assign bus.done      = state_q == S_DONE;
    assign bus.cfg_err   = err_q;
    assign bus.in_rd_en  = (state_q == S_PRIME && len_q != '0) || (state_q == S_STREAM && k1 < n_ext);
    assign bus.in_addr   = state_q == S_STREAM ? ADDR_W'(k1) : '0;
    assign bus.wt_rd_en  = state_q == S_PRIME || (state_q == S_STREAM && k1 <= last_k);
    assign bus.wt_addr   = state_q == S_STREAM ? WADDR_W'(k1) : '0;
    assign bus.arr_clr_n = state_q == S_STREAM || state_q == S_READOUT;
    // zero whenever no read landed, so the drain cycles feed exact zeros
    assign bus.arr_input = rv_q ? bus.in_rd_data : '0;
    assign bus.res_valid = state_q == S_READOUT;
    assign bus.res_idx   = idx_q;
    assign bus.res_data  = state_q != S_READOUT ? '0 : (relu_q && col[31]) ? '0 : col;
endmodule

// File: doc/fcn_layer_sequencer.md
Name: fcn_layer_sequencer

Overview:
- Sequences one fully-connected layer pass through the systolic MAC array.
- Clears the array, streams N input activations from the input buffer one per cycle, and issues skewed weight-row addresses to the weight RAM. The weight RAM drives the array's per-column weight bus directly.
- Waits for the array to drain, then reads out the SIZE column results over a valid/ready stream with optional ReLU.
- Sits between the coprocessor command front end (start/done) and the array plus its two buffers.

Parameters:
SIZE, 100, array column count (neurons per pass)
IN_MAX, 1024, maximum supported input length N
ADDR_W, 10, input-buffer address width (2^ADDR_W >= IN_MAX)
WADDR_W, 11, weight-RAM row address width (2^WADDR_W >= IN_MAX+SIZE-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; accepted only in IDLE
cfg_len  in  ADDR_W+1  input length N, sampled on accepted start
cfg_relu  in  1  ReLU enable, sampled on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after last result accepted or on error
cfg_err  out  1  sticky; set when N>IN_MAX; cleared on next accepted start
in_rd_en  out  1  input-buffer read strobe (1-cycle read latency)
in_addr  out  ADDR_W  input-buffer address
in_rd_data  in  32  signed activation, valid the cycle after in_rd_en
wt_rd_en  out  1  weight-RAM read strobe (1-cycle latency, data to array)
wt_addr  out  WADDR_W  skewed weight row r
arr_clr_n  out  1  array synchronous clear, active low
arr_input  out  32  signed activation into array column 0
arr_out  in  32*SIZE  flattened array accumulators; column j at bits [32j+31:32j]
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_idx  out  $clog2(SIZE)  column index of current result
res_data  out  32  signed result (ReLU applied if enabled)

Behaviour:
- Reset values: busy=0, done=0, cfg_err=0, in_rd_en=0, wt_rd_en=0, arr_clr_n=0, arr_input=0, res_valid=0, res_idx=0, res_data=0, state=IDLE.
- Async reset mid-operation aborts to IDLE. No done is generated.
- States: IDLE, PRIME, STREAM, READOUT, DONE.
- IDLE: arr_clr_n=0 (array held cleared). All strobes are low.
  - start with N>IN_MAX: set cfg_err, go to DONE.
  - Any other start: latch N and relu, clear cfg_err, go to PRIME.
- PRIME (1 cycle): arr_clr_n=0.
  - Issue wt_addr=0.
  - If N>0, issue in_addr=0 and in_rd_en=1.
  - Next state: STREAM if N>0, else READOUT.
- STREAM lasts exactly N+SIZE-1 cycles, k=0..N+SIZE-2, with arr_clr_n=1.
  - arr_input = in_rd_data if a read was issued the previous cycle, else 0. It is combinational from the registered read-valid flag, so it is exactly 0 during drain.
  - Next-cycle issue: in_addr=k+1 while k+1<N; wt_addr=k+1 while k+1<=N+SIZE-2.
- Weight RAM layout: row r column j holds W[r-j][j]. Out-of-range entries are don't-care, because they always meet a zero activation.
- READOUT: arr_clr_n=1, arr_input=0. Array outputs are stable, since all propagation registers hold 0.
  - res_valid=1, res_data = arr_out[res_idx], or max(0, value) when relu is set.
  - res_idx advances on res_valid&&res_ready.
  - res_valid and res_idx/res_data must hold steady while res_ready=0.
  - After acceptance of idx SIZE-1, go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- start is ignored outside IDLE. start in the DONE cycle is also ignored.
- Latency (start accepted at cycle t, res_ready tied 1):
  - First res_valid at cycle t+N+SIZE+1.
  - done at t+N+2*SIZE+1.
  - For N=0: first res_valid at t+2, all results 0.
- Counters must cover N+SIZE-2 without wrap. No arithmetic on data other than the ReLU sign test.

Test Plan:
- SIZE=4, N=2, x=[1,2], W=[[1,2,3,4],[5,6,7,8]] skewed in RAM, relu=0, ready=1 -> res_data 11,14,17,20 at idx 0..3; first valid at t+7; done at t+11.
- Same as the previous scenario, but W row 1 negated, relu=1 -> raw values -9,-10,-11,-12 clamp to 0,0,0,0. Then rerun with relu=0 -> -9,-10,-11,-12.
- res_ready toggled 1,0,0,1 during readout -> res_idx/res_data held while ready=0; no result skipped or duplicated; done only after idx 3 is accepted.
- N=0 -> no in_rd_en pulses; results 0,0,0,0. cfg_len=IN_MAX+1 -> cfg_err=1, done one cycle after start, no memory reads. Next valid start clears cfg_err.
- Back-to-back starts with N=3 then N=1 -> second pass results unaffected by the first (array cleared). A start asserted while busy produces no effect.
- rst_n deasserted mid-STREAM -> all outputs immediately return to reset values. A subsequent start with N=2 yields correct results.
